// File: rtl/pipe_stage_seq.sv
// Stage sequencer: walks a step counter through programmable stage boundaries,
// decoding the current stage and pulsing accumulator clears on stage entry.
//
// state | meaning
// IDLE  | waiting for a valid start; stage/step/mode forced to 0
// RUN   | counting steps on step_en_i; stage decoded from step
// DONE  | last boundary reached; step held, stage = NUM_STAGES
module pipe_stage_seq #(
  parameter  int NUM_STAGES = 8,
  parameter  int STEP_W     = 16,
  localparam int STAGE_W    = $clog2(NUM_STAGES + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic                         step_en_i,
  input  logic [NUM_STAGES*STEP_W-1:0] stage_boundary_i,
  input  logic [NUM_STAGES-1:0]        clr_mask_i,
  input  logic [NUM_STAGES-1:0]        mode_mask_i,
  output logic                         busy_o,
  output logic                         finished_o,
  output logic                         done_o,
  output logic [STAGE_W-1:0]           stage_o,
  output logic [STEP_W-1:0]            step_o,
  output logic                         mode_o,
  output logic                         acc_clr_o,
  output logic                         cfg_err_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [NUM_STAGES-1:0][STEP_W-1:0] bnd_t;

  state_t                  state_q, state_d;
  logic [STEP_W-1:0]       step_q, step_d;
  bnd_t                    bnd_q, bnd_d, bnd_in;
  logic [NUM_STAGES-1:0]   clr_q, clr_d, mode_q, mode_d;
  logic                    fin_q, fin_d, acc_clr_q, acc_clr_d, cfg_err_q, cfg_err_d;
  logic                    mono_ok;
  logic [STEP_W-1:0]       step_inc;
  logic [STAGE_W-1:0]      cur_stage, inc_stage, start_stage;

  // Smallest k with s < b[k]; empty stages are skipped naturally.
  function automatic logic [STAGE_W-1:0] decode(input logic [STEP_W-1:0] s, input bnd_t b);
    decode = STAGE_W'(NUM_STAGES);
    for (int k = NUM_STAGES - 1; k >= 0; k--)
      if (s < b[k]) decode = STAGE_W'(k);
  endfunction

  function automatic logic bit_at(input logic [NUM_STAGES-1:0] m, input logic [STAGE_W-1:0] idx);
    bit_at = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++)
      if (idx == STAGE_W'(k)) bit_at = m[k];
  endfunction

  assign bnd_in = stage_boundary_i;

  always_comb begin
    mono_ok = 1'b1;
    for (int k = 0; k < NUM_STAGES - 1; k++)
      if (bnd_in[k] > bnd_in[k+1]) mono_ok = 1'b0;
  end

  assign cur_stage   = decode(step_q, bnd_q);
  assign step_inc    = step_q + STEP_W'(1);
  assign inc_stage   = decode(step_inc, bnd_q);
  assign start_stage = decode(STEP_W'(0), bnd_in);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    bnd_d     = bnd_q;
    clr_d     = clr_q;
    mode_d    = mode_q;
    fin_d     = 1'b0;
    acc_clr_d = 1'b0;
    cfg_err_d = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
      step_d  = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            step_d = '0;
            if (!mono_ok) begin
              state_d   = IDLE;
              cfg_err_d = 1'b1;
            end else begin
              bnd_d  = bnd_in;
              clr_d  = clr_mask_i;
              mode_d = mode_mask_i;
              // All stages empty: the run is complete before it starts.
              if (bnd_in[NUM_STAGES-1] == '0) begin
                state_d = DONE;
                fin_d   = 1'b1;
              end else begin
                state_d   = RUN;
                acc_clr_d = bit_at(clr_mask_i, start_stage);
              end
            end
          end
        end
        RUN: begin
          if (step_en_i && (step_q != '1)) begin
            step_d = step_inc;
            if (step_inc >= bnd_q[NUM_STAGES-1]) begin
              state_d = DONE;
              fin_d   = 1'b1;
            end else if (inc_stage != cur_stage) begin
              acc_clr_d = bit_at(clr_q, inc_stage);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      step_q    <= '0;
      bnd_q     <= '0;
      clr_q     <= '0;
      mode_q    <= '0;
      fin_q     <= 1'b0;
      acc_clr_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      bnd_q     <= bnd_d;
      clr_q     <= clr_d;
      mode_q    <= mode_d;
      fin_q     <= fin_d;
      acc_clr_q <= acc_clr_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign busy_o     = (state_q == RUN);
  assign done_o     = (state_q == DONE);
  assign finished_o = fin_q;
  assign acc_clr_o  = acc_clr_q;
  assign cfg_err_o  = cfg_err_q;
  assign step_o     = step_q;
  assign stage_o    = (state_q == RUN)  ? cur_stage :
                      (state_q == DONE) ? STAGE_W'(NUM_STAGES) : '0;
  assign mode_o     = (state_q == RUN) && bit_at(mode_q, cur_stage);

endmodule

// File: tb/tb_pipe_stage_seq.sv
// Scoreboard bench for pipe_stage_seq (4 stages, 16-bit step): directed vectors
// push expected outputs; a monitor pops and compares one entry per cycle.
module tb_pipe_stage_seq;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int SW = $clog2(N + 1);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0, step_en_i = 1'b0;
  logic [N*W-1:0] stage_boundary_i = '0;
  logic [N-1:0]  clr_mask_i = '0, mode_mask_i = '0;
  logic          busy_o, finished_o, done_o, mode_o, acc_clr_o, cfg_err_o;
  logic [SW-1:0] stage_o;
  logic [W-1:0]  step_o;

  typedef struct packed {
    logic          busy;
    logic          fin;
    logic          done;
    logic [SW-1:0] stage;
    logic [W-1:0]  step;
    logic          mode;
    logic          acc;
    logic          err;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  pipe_stage_seq #(.NUM_STAGES(N), .STEP_W(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .step_en_i(step_en_i), .stage_boundary_i(stage_boundary_i),
    .clr_mask_i(clr_mask_i), .mode_mask_i(mode_mask_i),
    .busy_o(busy_o), .finished_o(finished_o), .done_o(done_o),
    .stage_o(stage_o), .step_o(step_o), .mode_o(mode_o),
    .acc_clr_o(acc_clr_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic obs_t ex(input logic busy, fin, done, input logic [SW-1:0] stg,
                              input logic [W-1:0] stp, input logic mode, acc, err);
    obs_t o;
    o.busy = busy; o.fin = fin; o.done = done; o.stage = stg;
    o.step = stp;  o.mode = mode; o.acc = acc;  o.err = err;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("busy=%0b fin=%0b done=%0b stage=%0d step=%0d mode=%0b acc_clr=%0b cfg_err=%0b",
                     o.busy, o.fin, o.done, o.stage, o.step, o.mode, o.acc, o.err);
  endfunction

  task automatic set_cfg(input logic [W-1:0] b3, b2, b1, b0, input logic [N-1:0] clr, mode);
    stage_boundary_i = {b3, b2, b1, b0};
    clr_mask_i       = clr;
    mode_mask_i      = mode;
  endtask

  task automatic cyc(input logic rs, st, ab, en, input obs_t e, input string nm);
    @(negedge clk_i);
    rst_i = rs; start_i = st; abort_i = ab; step_en_i = en;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares the outputs following each edge for which an expectation exists.
  initial begin
    obs_t got, e;
    string nm;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        got = ex(busy_o, finished_o, done_o, stage_o, step_o, mode_o, acc_clr_o, cfg_err_o);
        n_checks++;
        if (got === e) n_pass++;
        else $display("FAIL %s: got %s, expected %s", nm, fmt(got), fmt(e));
      end
    end
  end

  obs_t z;

  initial begin
    z = ex(0,0,0,0,0,0,0,0);
    cyc(1,0,0,0, z, "reset");
    cyc(0,0,0,0, z, "idle");

    // b={2,5,5,7} clr={1,1,1,0} mode={1,1,0,0}
    set_cfg(16'd7, 16'd5, 16'd5, 16'd2, 4'b0111, 4'b0011);
    cyc(0,1,0,0, ex(1,0,0,0,0,1,1,0), "a_start");
    cyc(0,0,0,1, ex(1,0,0,0,1,1,0,0), "a_s1");
    cyc(0,0,0,1, ex(1,0,0,1,2,1,1,0), "a_s2");
    cyc(0,0,0,1, ex(1,0,0,1,3,1,0,0), "a_s3");
    cyc(0,0,0,1, ex(1,0,0,1,4,1,0,0), "a_s4");
    cyc(0,0,0,1, ex(1,0,0,3,5,0,0,0), "a_s5_skip");
    cyc(0,0,0,1, ex(1,0,0,3,6,0,0,0), "a_s6");
    cyc(0,0,0,1, ex(0,1,1,4,7,0,0,0), "a_finish");
    cyc(0,0,0,1, ex(0,0,1,4,7,0,0,0), "a_done_hold");

    // Restart from DONE, gated stepping, start ignored in RUN, abort priority
    cyc(0,1,0,0, ex(1,0,0,0,0,1,1,0), "b_restart");
    cyc(0,0,0,1, ex(1,0,0,0,1,1,0,0), "b_en1");
    cyc(0,0,0,0, ex(1,0,0,0,1,1,0,0), "b_hold1");
    set_cfg(16'd0, 16'd0, 16'd0, 16'd0, 4'b1111, 4'b0000);
    cyc(0,1,0,0, ex(1,0,0,0,1,1,0,0), "b_start_ignored");
    cyc(0,0,0,1, ex(1,0,0,1,2,1,1,0), "b_en2");
    cyc(0,0,0,0, ex(1,0,0,1,2,1,0,0), "b_hold2");
    cyc(0,1,1,1, z, "b_abort");
    cyc(0,0,0,0, z, "b_idle");

    // Reset and abort mid-run at step 3
    set_cfg(16'd7, 16'd5, 16'd5, 16'd2, 4'b0111, 4'b0011);
    cyc(0,1,0,0, ex(1,0,0,0,0,1,1,0), "c_start");
    cyc(0,0,0,1, ex(1,0,0,0,1,1,0,0), "c_s1");
    cyc(0,0,0,1, ex(1,0,0,1,2,1,1,0), "c_s2");
    cyc(0,0,0,1, ex(1,0,0,1,3,1,0,0), "c_s3");
    cyc(1,0,0,1, z, "c_reset");
    cyc(0,0,0,0, z, "c_after_reset");
    cyc(0,1,0,0, ex(1,0,0,0,0,1,1,0), "c2_start");
    cyc(0,0,0,1, ex(1,0,0,0,1,1,0,0), "c2_s1");
    cyc(0,0,0,1, ex(1,0,0,1,2,1,1,0), "c2_s2");
    cyc(0,0,0,1, ex(1,0,0,1,3,1,0,0), "c2_s3");
    cyc(0,0,1,1, z, "c_abort");
    cyc(0,0,0,0, z, "c_after_abort");

    // Decreasing boundaries b={3,2,4,6}
    set_cfg(16'd6, 16'd4, 16'd2, 16'd3, 4'b1111, 4'b1111);
    cyc(0,1,0,0, ex(0,0,0,0,0,0,0,1), "d_cfg_err");
    cyc(0,0,0,0, z, "d_idle");

    // All-zero boundaries: straight to DONE
    set_cfg(16'd0, 16'd0, 16'd0, 16'd0, 4'b1111, 4'b1111);
    cyc(0,1,0,0, ex(0,1,1,4,0,0,0,0), "e_zero_start");
    cyc(0,0,0,1, ex(0,0,1,4,0,0,0,0), "e_done_hold");
    set_cfg(16'd6, 16'd4, 16'd2, 16'd3, 4'b1111, 4'b1111);
    cyc(0,1,0,0, ex(0,0,0,0,0,0,0,1), "e_bad_from_done");
    cyc(0,0,0,0, z, "e_idle");

    // Empty first stage: b={0,3,3,4} clr={0,1,0,1} mode={0,0,1,1}
    set_cfg(16'd4, 16'd3, 16'd3, 16'd0, 4'b1010, 4'b1100);
    cyc(0,1,0,0, ex(1,0,0,1,0,0,1,0), "f_start_skip0");
    cyc(0,0,0,1, ex(1,0,0,1,1,0,0,0), "f_s1");
    cyc(0,0,0,1, ex(1,0,0,1,2,0,0,0), "f_s2");
    cyc(0,0,0,1, ex(1,0,0,3,3,1,1,0), "f_s3_skip2");
    cyc(0,0,0,1, ex(0,1,1,4,4,0,0,0), "f_finish");
    cyc(0,0,0,0, ex(0,0,1,4,4,0,0,0), "f_done_hold");

    repeat (3) @(posedge clk_i);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
